// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave backed by a word-addressed memory with an optional
// read-only window at the bottom and SLVERR for out-of-range accesses.
module axi_lite_mem_slave #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DATA_DEPTH = 512,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           RO_DEPTH   = 0
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  function automatic logic [ADDR_WIDTH-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
    return (a - BASE_ADDR) >> LSB;
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] w;
    w = word_of(a);
    return (a >= BASE_ADDR) && ((w >> IDX_W) == '0);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  logic                  aw_full, w_full;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;

  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                  commit, c_ok, r_ok;
  logic [ADDR_WIDTH-1:0] c_addr, c_word, r_word;
  logic [DATA_WIDTH-1:0] c_data;
  logic [STRB_W-1:0]     c_strb;
  logic [IDX_W-1:0]      c_idx, r_idx;
  logic                  aw_full_n, w_full_n, bvalid_n, rvalid_n;

  always_comb begin
    aw_hs  = awvalid & awready;
    w_hs   = wvalid & wready;
    b_hs   = bvalid & bready;
    ar_hs  = arvalid & arready;
    r_hs   = rvalid & rready;
    // A slot that fills on this edge commits together with the already-full one
    c_addr = aw_full ? aw_addr : awaddr;
    c_data = w_full ? w_data : wdata;
    c_strb = w_full ? w_strb : wstrb;
    commit = (aw_full | aw_hs) & (w_full | w_hs) & ~bvalid;
    c_word = word_of(c_addr);
    c_idx  = c_word[IDX_W-1:0];
    c_ok   = in_range(c_addr) && !(c_word < ADDR_WIDTH'(RO_DEPTH));
    r_word = word_of(araddr);
    r_idx  = r_word[IDX_W-1:0];
    r_ok   = in_range(araddr);
    aw_full_n = ~b_hs & (aw_full | aw_hs);
    w_full_n  = ~b_hs & (w_full | w_hs);
    bvalid_n  = ~b_hs & (bvalid | commit);
    rvalid_n  = ar_hs | (rvalid & ~r_hs);
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rresp   <= RESP_OKAY;
      rdata   <= '0;
    end else begin
      aw_full <= aw_full_n;
      w_full  <= w_full_n;
      bvalid  <= bvalid_n;
      awready <= ~aw_full_n & ~bvalid_n;
      wready  <= ~w_full_n & ~bvalid_n;
      if (aw_hs) aw_addr <= awaddr;
      if (w_hs) begin
        w_data <= wdata;
        w_strb <= wstrb;
      end
      if (commit) bresp <= c_ok ? RESP_OKAY : RESP_SLVERR;

      rvalid  <= rvalid_n;
      arready <= ~rvalid_n;
      if (ar_hs) begin
        rdata <= r_ok ? mem[r_idx] : '0;
        rresp <= r_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Storage is deliberately not reset; only the handshake state is.
  always_ff @(posedge aclk) begin
    if (areset_n && commit && c_ok) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (c_strb[i]) mem[c_idx][8*i +: 8] <= c_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed bench for axi_lite_mem_slave: a vector table plus hand-timed
// sequences for handshake ordering, back-pressure, read/write collision and reset.
module tb_axi_lite_mem_slave;

  logic        aclk = 1'b0;
  logic        areset_n = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        awready_1, wready_1, bvalid_1, arready_1, rvalid_1;
  logic [1:0]  bresp_1, rresp_1;
  logic [31:0] rdata_1;

  always #5 aclk = ~aclk;

  axi_lite_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DATA_DEPTH(16),
                       .BASE_ADDR(32'h0), .RO_DEPTH(4)) u_dut (
    .aclk(aclk), .areset_n(areset_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready));

  // Same stimulus, no read-only window: used where word 3 must be writable.
  axi_lite_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DATA_DEPTH(16),
                       .BASE_ADDR(32'h0), .RO_DEPTH(0)) u_dut_rw (
    .aclk(aclk), .areset_n(areset_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready_1),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_1),
    .bresp(bresp_1), .bvalid(bvalid_1), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready_1),
    .rdata(rdata_1), .rresp(rresp_1), .rvalid(rvalid_1), .rready(rready));

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  int unsigned total = 0, passed = 0;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rexp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_aw(input logic [31:0] a);
    awaddr = a; awvalid = 1'b1;
    for (int i = 0; i < 16 && !awready; i++) tick();
    chk("aw_accept", awready, 1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int i = 0; i < 16 && !wready; i++) tick();
    chk("w_accept", wready, 1);
    tick();
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 16 && !arready; i++) tick();
    chk("ar_accept", arready, 1);
    tick();
    arvalid = 1'b0;
  endtask

  task automatic wait_b(input string name, input logic [1:0] exp);
    bready = 1'b1;
    for (int i = 0; i < 16 && !bvalid; i++) tick();
    chk({name, "_bvalid"}, bvalid, 1);
    chk({name, "_bresp"}, bresp, exp);
    tick();
    bready = 1'b0;
  endtask

  task automatic wait_r(input string name, input logic [1:0] exp_resp, input logic [31:0] exp_data);
    rready = 1'b1;
    for (int i = 0; i < 16 && !rvalid; i++) tick();
    chk({name, "_rvalid"}, rvalid, 1);
    chk({name, "_rresp"}, rresp, exp_resp);
    chk({name, "_rdata"}, rdata, exp_data);
    tick();
    rready = 1'b0;
  endtask

  initial begin
    // Table: DEPTH 16 words, words 0..3 read-only, byte 0x40 is first out-of-range
    vecs.push_back('{1, 32'h14, 32'hAABBCCDD, 4'hF, OKAY,   32'h0});
    vecs.push_back('{1, 32'h14, 32'h00001100, 4'h6, OKAY,   32'h0});
    vecs.push_back('{0, 32'h14, 32'h0,        4'h0, OKAY,   32'hAA0011DD});
    vecs.push_back('{1, 32'h17, 32'h12345678, 4'h0, OKAY,   32'h0});
    vecs.push_back('{0, 32'h15, 32'h0,        4'h0, OKAY,   32'hAA0011DD});
    vecs.push_back('{1, 32'h3C, 32'hCAFEF00D, 4'hF, OKAY,   32'h0});
    vecs.push_back('{0, 32'h3F, 32'h0,        4'h0, OKAY,   32'hCAFEF00D});
    vecs.push_back('{1, 32'h40, 32'h11111111, 4'hF, SLVERR, 32'h0});
    vecs.push_back('{0, 32'h40, 32'h0,        4'h0, SLVERR, 32'h0});
    vecs.push_back('{0, 32'hFFFFFFFC, 32'h0,  4'h0, SLVERR, 32'h0});
    vecs.push_back('{1, 32'h08, 32'hBADC0DE5, 4'hF, SLVERR, 32'h0});
    vecs.push_back('{1, 32'h1C, 32'h77777777, 4'hF, OKAY,   32'h0});
    vecs.push_back('{0, 32'h1C, 32'h0,        4'h0, OKAY,   32'h77777777});

    #1 areset_n = 1'b0;
    repeat (3) tick();
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bresp", bresp, OKAY);
    chk("rst_rresp", rresp, OKAY);
    chk("rst_rdata", rdata, 0);
    areset_n = 1'b1;
    tick();
    chk("rel_awready", awready, 1);
    chk("rel_wready", wready, 1);
    chk("rel_arready", arready, 1);

    // AW first, W three cycles later
    awaddr = 32'h10; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("a_awready_low", awready, 0);
    tick(); tick();
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    chk("a_wready", wready, 1);
    chk("a_bvalid_early", bvalid, 0);
    tick();
    wvalid = 1'b0;
    chk("a_bvalid", bvalid, 1);
    chk("a_bresp", bresp, OKAY);
    chk("a_wready_low", wready, 0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("a_bvalid_clr", bvalid, 0);
    chk("a_awready_back", awready, 1);
    chk("a_wready_back", wready, 1);
    araddr = 32'h10; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("a_rvalid", rvalid, 1);
    chk("a_rdata", rdata, 32'hDEADBEEF);
    chk("a_rresp", rresp, OKAY);
    chk("a_arready_low", arready, 0);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("a_rvalid_clr", rvalid, 0);
    chk("a_arready_back", arready, 1);

    // W before AW, single-lane strobe
    wdata = 32'h0000AA00; wstrb = 4'h2; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("b_wready_low", wready, 0);
    chk("b_bvalid_early", bvalid, 0);
    tick();
    awaddr = 32'h10; awvalid = 1'b1;
    chk("b_bvalid_early2", bvalid, 0);
    tick();
    awvalid = 1'b0;
    chk("b_bvalid", bvalid, 1);
    chk("b_bresp", bresp, OKAY);
    wait_b("b", OKAY);
    send_ar(32'h10);
    wait_r("b_rd", OKAY, 32'hDEADAAEF);

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        send_aw(vecs[i].addr);
        send_w(vecs[i].data, vecs[i].strb);
        wait_b($sformatf("vec%0d", i), vecs[i].resp);
      end else begin
        send_ar(vecs[i].addr);
        wait_r($sformatf("vec%0d", i), vecs[i].resp, vecs[i].rexp);
      end
    end

    // Read-only word rejected the table's write; the RW instance took it
    send_ar(32'h08);
    chk("ro_rresp", rresp, OKAY);
    chk("ro_unchanged", rdata == 32'hBADC0DE5, 0);
    chk("rw_written", rdata_1, 32'hBADC0DE5);
    rready = 1'b1;
    tick();
    rready = 1'b0;

    // Back-pressure on B and R
    send_aw(32'h18);
    send_w(32'h5A5A5A5A, 4'hF);
    for (int i = 0; i < 5; i++) begin
      chk("c_bvalid_hold", bvalid, 1);
      chk("c_bresp_hold", bresp, OKAY);
      chk("c_awready_hold", awready, 0);
      chk("c_wready_hold", wready, 0);
      tick();
    end
    wait_b("c", OKAY);
    send_ar(32'h18);
    for (int i = 0; i < 5; i++) begin
      chk("c_rvalid_hold", rvalid, 1);
      chk("c_rdata_hold", rdata, 32'h5A5A5A5A);
      chk("c_rresp_hold", rresp, OKAY);
      chk("c_arready_hold", arready, 0);
      tick();
    end
    wait_r("c_rd", OKAY, 32'h5A5A5A5A);

    // Word 3: same-cycle AW+W, then read colliding with the next commit
    awaddr = 32'h0C; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("e_bvalid_rw", bvalid_1, 1);
    chk("e_bresp_rw", bresp_1, OKAY);
    chk("e_bresp_ro", bresp, SLVERR);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    awaddr = 32'h0C; wdata = 32'h2; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h0C; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("e_rvalid", rvalid_1, 1);
    chk("e_rdata_old", rdata_1, 32'h1);
    chk("e_bvalid2", bvalid_1, 1);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    send_ar(32'h0C);
    chk("e_rdata_new", rdata_1, 32'h2);
    rready = 1'b1;
    tick();
    rready = 1'b0;

    // Reset with AW captured, W about to be offered and a read pending
    awaddr = 32'h1C; awvalid = 1'b1; araddr = 32'h1C; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    chk("f_rvalid_pre", rvalid, 1);
    chk("f_awready_pre", awready, 0);
    wdata = 32'h0; wstrb = 4'hF; wvalid = 1'b1;
    #1 areset_n = 1'b0;
    #1;
    chk("f_awready", awready, 0);
    chk("f_wready", wready, 0);
    chk("f_arready", arready, 0);
    chk("f_bvalid", bvalid, 0);
    chk("f_rvalid", rvalid, 0);
    chk("f_rdata", rdata, 0);
    chk("f_rvalid_rw", rvalid_1, 0);
    wvalid = 1'b0;
    tick(); tick();
    areset_n = 1'b1;
    tick();
    chk("f_awready_rel", awready, 1);
    chk("f_wready_rel", wready, 1);
    chk("f_arready_rel", arready, 1);
    chk("f_bvalid_rel", bvalid, 0);
    chk("f_ready_rw", {awready_1, wready_1, arready_1, bvalid_1}, 4'b1110);
    chk("f_resp_rw", {bresp_1, rresp_1}, 4'b0000);
    send_aw(32'h20);
    send_w(32'h12121212, 4'hF);
    wait_b("f_wr", OKAY);
    send_ar(32'h20);
    wait_r("f_rd_new", OKAY, 32'h12121212);
    send_ar(32'h1C);
    wait_r("f_rd_keep", OKAY, 32'h77777777);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
